// File: rtl/cam_pkg.sv
// Shared types and default sizes for the cam_search lookup stage.
package cam_pkg;

  localparam int CAM_KEY_W  = 8;
  localparam int CAM_DEPTH  = 16;
  localparam int CAM_ADDR_W = $clog2(CAM_DEPTH);

  typedef logic [CAM_KEY_W-1:0]  key_t;
  typedef logic [CAM_ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  hit;
    logic  multi;
    addr_t addr;
  } cam_result_t;

endpackage

// File: rtl/cam_search_if.sv
// Search, result and control signals of cam_search; master drives, slave is the CAM.
interface cam_search_if #(
  parameter int KEY_W = cam_pkg::CAM_KEY_W,
  parameter int DEPTH = cam_pkg::CAM_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_key;
  logic              inv_en;
  logic [ADDR_W-1:0] inv_addr;
  logic              flush;
  logic              srch_valid;
  logic [KEY_W-1:0]  srch_key;
  logic              srch_ready;
  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [ADDR_W-1:0] res_addr;
  logic              res_multi;

  modport master (
    output wr_en, wr_addr, wr_key, inv_en, inv_addr, flush,
    output srch_valid, srch_key, res_ready,
    input  srch_ready, res_valid, res_hit, res_addr, res_multi
  );

  modport slave (
    input  wr_en, wr_addr, wr_key, inv_en, inv_addr, flush,
    input  srch_valid, srch_key, res_ready,
    output srch_ready, res_valid, res_hit, res_addr, res_multi
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over a match vector, with hit and multi-hit flags.
module cam_prio_enc #(
  parameter int DEPTH  = cam_pkg::CAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  i_match,
  output logic              o_hit,
  output logic              o_multi,
  output logic [ADDR_W-1:0] o_addr
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_addr = {ADDR_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      o_addr = i_match[i] ? ADDR_W'(i) : o_addr;
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  always_comb begin
    o_hit   = |i_match;
    o_multi = |(i_match & (i_match - DEPTH'(1)));
  end

endmodule

// File: rtl/cam_search.sv
// Two-stage CAM lookup: S1 snapshots the match vector, S2 encodes it; control port edits entries.
module cam_search
  import cam_pkg::*;
#(
  parameter int KEY_W  = CAM_KEY_W,
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  cam_search_if.slave  bus
);

  logic [KEY_W-1:0]  r_keys [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [DEPTH-1:0]  w_match;
  logic [DEPTH-1:0]  r_match;
  logic              r_s1_valid;
  logic              r_res_valid;
  logic              r_res_hit;
  logic              r_res_multi;
  logic [ADDR_W-1:0] r_res_addr;
  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_accept;
  logic              w_enc_hit;
  logic              w_enc_multi;
  logic [ADDR_W-1:0] w_enc_addr;

  assign w_s2_free      = !r_res_valid || bus.res_ready;
  assign w_s1_adv       = r_s1_valid && w_s2_free;
  assign bus.srch_ready = !r_s1_valid || w_s2_free;
  assign w_accept       = bus.srch_valid && bus.srch_ready;

  // Compare against current contents, i.e. before any same-cycle control update.
  always_comb begin
    w_match = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_keys[i] == bus.srch_key);
    end
  end

  // Per-entry control priority: write beats invalidate beats flush.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
        w_valid_nxt[i] = 1'b1;
      end else if (bus.inv_en && (bus.inv_addr == ADDR_W'(i))) begin
        w_valid_nxt[i] = 1'b0;
      end else if (bus.flush) begin
        w_valid_nxt[i] = 1'b0;
      end else begin
        w_valid_nxt[i] = r_valid[i];
      end
    end
  end

  // Key storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_keys[bus.wr_addr] <= bus.wr_key;
    end
  end

  // Entry valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= {DEPTH{1'b0}};
    end else begin
      r_valid <= w_valid_nxt;
    end
  end

  // S1: match-vector snapshot taken at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_match    <= {DEPTH{1'b0}};
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_match    <= w_match;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  cam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_enc (
    .i_match (r_match),
    .o_hit   (w_enc_hit),
    .o_multi (w_enc_multi),
    .o_addr  (w_enc_addr)
  );

  // S2: encoded result register, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_multi <= 1'b0;
      r_res_addr  <= {ADDR_W{1'b0}};
    end else if (w_s1_adv) begin
      r_res_valid <= 1'b1;
      r_res_hit   <= w_enc_hit;
      r_res_multi <= w_enc_multi;
      r_res_addr  <= w_enc_addr;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_hit   = r_res_hit;
  assign bus.res_multi = r_res_multi;
  assign bus.res_addr  = r_res_addr;

endmodule

// File: tb/tb_cam_search.sv
// Self-checking bench for cam_search: directed table, stall/reset sequences, random traffic vs. a model.
module tb_cam_search;
  import cam_pkg::*;

  localparam int KW = CAM_KEY_W;
  localparam int DP = CAM_DEPTH;
  localparam int AW = CAM_ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cam_search_if #(.KEY_W(KW), .DEPTH(DP)) bus_if ();

  cam_search #(.KEY_W(KW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic hit;
    logic multi;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [KW-1:0] wr_key;
    logic          inv_en;
    logic [AW-1:0] inv_addr;
    logic          flush;
    logic          srch;
    logic [KW-1:0] key;
    logic          e_hit;
    logic [AW-1:0] e_addr;
    logic          e_multi;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [KW-1:0] m_key [DP];
  logic          m_val [DP];
  exp_t          exp_q [$];

  logic          hold_chk = 1'b0;
  exp_t          hold_res;
  logic          lr_got;
  exp_t          lr;
  logic          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model_search(input logic [KW-1:0] k);
    exp_t r;
    int   cnt = 0;
    r.addr = '0;
    for (int i = 0; i < DP; i++) begin
      if (m_val[i] && m_key[i] == k) begin
        if (cnt == 0) r.addr = AW'(i);
        cnt++;
      end
    end
    r.hit   = (cnt > 0);
    r.multi = (cnt >= 2);
    return r;
  endfunction

  // One clock: inputs are stable from the preceding negedge; sample, model, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (reset) begin
      if (hold_chk) begin
        chk("stall_valid", 32'(bus_if.res_valid), 32'd1);
        chk("stall_result", {bus_if.res_hit, bus_if.res_multi, 32'(bus_if.res_addr)},
            {hold_res.hit, hold_res.multi, 32'(hold_res.addr)});
      end
      if (bus_if.res_valid && bus_if.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_hit",   32'(bus_if.res_hit),   32'(e.hit));
          chk("res_addr",  32'(bus_if.res_addr),  32'(e.addr));
          chk("res_multi", 32'(bus_if.res_multi), 32'(e.multi));
        end
        lr_got   = 1'b1;
        lr.hit   = bus_if.res_hit;
        lr.multi = bus_if.res_multi;
        lr.addr  = bus_if.res_addr;
      end
      hold_chk      = bus_if.res_valid && !bus_if.res_ready;
      hold_res.hit   = bus_if.res_hit;
      hold_res.multi = bus_if.res_multi;
      hold_res.addr  = bus_if.res_addr;
      if (bus_if.srch_valid && bus_if.srch_ready) begin
        last_acc = 1'b1;
        exp_q.push_back(model_search(bus_if.srch_key));
      end
      if (bus_if.flush) for (int i = 0; i < DP; i++) m_val[i] = 1'b0;
      if (bus_if.inv_en) m_val[bus_if.inv_addr] = 1'b0;
      if (bus_if.wr_en) begin
        m_val[bus_if.wr_addr] = 1'b1;
        m_key[bus_if.wr_addr] = bus_if.wr_key;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.wr_en      = 1'b0;
    bus_if.inv_en     = 1'b0;
    bus_if.flush      = 1'b0;
    bus_if.srch_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input int wa, input int wk, input logic ie,
                              input int ia, input logic fl, input logic s, input int k,
                              input logic eh, input int ea, input logic em);
    vec_t v;
    v.wr_en = we; v.wr_addr = AW'(wa); v.wr_key = KW'(wk);
    v.inv_en = ie; v.inv_addr = AW'(ia); v.flush = fl;
    v.srch = s; v.key = KW'(k);
    v.e_hit = eh; v.e_addr = AW'(ea); v.e_multi = em;
    return v;
  endfunction

  vec_t vt [20];
  logic [KW-1:0] bpk [3];

  initial begin
    for (int i = 0; i < DP; i++) begin
      m_key[i] = '0;
      m_val[i] = 1'b0;
    end
    idle_inputs();
    bus_if.wr_addr = '0; bus_if.wr_key = '0; bus_if.inv_addr = '0;
    bus_if.srch_key = '0; bus_if.res_ready = 1'b1;
    lr_got = 1'b0;
    lr = '{1'b0, 1'b0, '0};

    //          we wa wk     ie ia fl s  key    hit addr multi
    vt[0]  = mk(0, 0, 0,     0, 0, 0, 1, 8'h00, 0, 0,  0);
    vt[1]  = mk(1, 5, 8'hA3, 0, 0, 0, 0, 0,     0, 0,  0);
    vt[2]  = mk(0, 0, 0,     0, 0, 0, 1, 8'hA3, 1, 5,  0);
    vt[3]  = mk(0, 0, 0,     0, 0, 0, 1, 8'hA4, 0, 0,  0);
    vt[4]  = mk(1, 3, 8'h5C, 0, 0, 0, 0, 0,     0, 0,  0);
    vt[5]  = mk(1, 9, 8'h5C, 0, 0, 0, 0, 0,     0, 0,  0);
    vt[6]  = mk(0, 0, 0,     0, 0, 0, 1, 8'h5C, 1, 3,  1);
    vt[7]  = mk(0, 0, 0,     1, 3, 0, 0, 0,     0, 0,  0);
    vt[8]  = mk(0, 0, 0,     0, 0, 0, 1, 8'h5C, 1, 9,  0);
    vt[9]  = mk(1, 2, 8'h11, 0, 0, 0, 1, 8'h11, 0, 0,  0);
    vt[10] = mk(0, 0, 0,     0, 0, 0, 1, 8'h11, 1, 2,  0);
    vt[11] = mk(1, 2, 8'h77, 0, 0, 1, 0, 0,     0, 0,  0);
    vt[12] = mk(0, 0, 0,     0, 0, 0, 1, 8'hA3, 0, 0,  0);
    vt[13] = mk(0, 0, 0,     0, 0, 0, 1, 8'h5C, 0, 0,  0);
    vt[14] = mk(0, 0, 0,     0, 0, 0, 1, 8'h77, 1, 2,  0);
    vt[15] = mk(1, 2, 8'h88, 1, 2, 0, 0, 0,     0, 0,  0);
    vt[16] = mk(0, 0, 0,     0, 0, 0, 1, 8'h88, 1, 2,  0);
    vt[17] = mk(1, 15, 8'hFF, 0, 0, 0, 1, 8'hFF, 0, 0, 0);
    vt[18] = mk(1, 0, 8'hFF, 0, 0, 0, 1, 8'hFF, 1, 15, 0);
    vt[19] = mk(0, 0, 0,     0, 0, 0, 1, 8'hFF, 1, 0,  1);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("rst_res_hit",   32'(bus_if.res_hit),   32'd0);
    chk("rst_res_addr",  32'(bus_if.res_addr),  32'd0);
    chk("rst_res_multi", 32'(bus_if.res_multi), 32'd0);
    chk("rst_srch_ready", 32'(bus_if.srch_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 20; v++) begin
      bus_if.wr_en = vt[v].wr_en;   bus_if.wr_addr = vt[v].wr_addr; bus_if.wr_key = vt[v].wr_key;
      bus_if.inv_en = vt[v].inv_en; bus_if.inv_addr = vt[v].inv_addr;
      bus_if.flush = vt[v].flush;   bus_if.srch_valid = vt[v].srch; bus_if.srch_key = vt[v].key;
      lr_got = 1'b0;
      cycle();
      idle_inputs();
      for (int k = 0; k < 4 && !lr_got; k++) cycle();
      chk($sformatf("vec%0d_got", v), 32'(lr_got), 32'(vt[v].srch));
      if (vt[v].srch) begin
        chk($sformatf("vec%0d_hit", v),   32'(lr.hit),   32'(vt[v].e_hit));
        chk($sformatf("vec%0d_addr", v),  32'(lr.addr),  32'(vt[v].e_addr));
        chk($sformatf("vec%0d_multi", v), 32'(lr.multi), 32'(vt[v].e_multi));
      end
    end

    // Backpressure: two keys fill S1/S2, the third must wait.
    bpk[0] = 8'hFF; bpk[1] = 8'h88; bpk[2] = 8'h42;
    begin
      int idx = 0;
      bus_if.res_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        bus_if.srch_valid = 1'b1;
        bus_if.srch_key   = bpk[idx];
        if (c == 2) chk("bp_ready_low", 32'(bus_if.srch_ready), 32'd0);
        cycle();
        if (last_acc) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      bus_if.res_ready = 1'b1;
      for (int c = 0; c < 6 && idx < 3; c++) begin
        bus_if.srch_key = bpk[idx];
        cycle();
        if (last_acc) idx++;
      end
      bus_if.srch_valid = 1'b0;
      for (int c = 0; c < 4; c++) cycle();
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus_if.wr_en      = ($urandom_range(0, 7) == 0);
      bus_if.wr_addr    = AW'($urandom_range(0, DP - 1));
      bus_if.wr_key     = KW'($urandom_range(0, 7));
      bus_if.inv_en     = ($urandom_range(0, 11) == 0);
      bus_if.inv_addr   = AW'($urandom_range(0, DP - 1));
      bus_if.flush      = ($urandom_range(0, 99) == 0);
      bus_if.srch_valid = ($urandom_range(0, 3) != 0);
      bus_if.srch_key   = KW'($urandom_range(0, 7));
      bus_if.res_ready  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle_inputs();
    bus_if.res_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Mid-flight reset with S1 and S2 both occupied.
    bus_if.wr_en = 1'b1; bus_if.wr_addr = AW'(4); bus_if.wr_key = 8'h3C;
    cycle();
    idle_inputs();
    bus_if.res_ready  = 1'b0;
    bus_if.srch_valid = 1'b1; bus_if.srch_key = 8'h3C;
    cycle();
    cycle();
    bus_if.srch_valid = 1'b0;
    chk("pre_rst_full", 32'(bus_if.srch_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(bus_if.res_valid), 32'd0);
    exp_q.delete();
    hold_chk = 1'b0;
    for (int i = 0; i < DP; i++) m_val[i] = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    bus_if.res_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    chk("post_rst_no_result", 32'(exp_q.size()), 32'd0);
    bus_if.srch_valid = 1'b1; bus_if.srch_key = 8'h3C;
    lr_got = 1'b0;
    cycle();
    bus_if.srch_valid = 1'b0;
    for (int k = 0; k < 4 && !lr_got; k++) cycle();
    chk("post_rst_got", 32'(lr_got), 32'd1);
    chk("post_rst_miss", {lr.hit, lr.multi, 32'(lr.addr)}, 34'd0);
    for (int c = 0; c < 4; c++) cycle();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
